// File: rtl/mul_seq.sv
// Sequential radix-2 shift-and-add multiplier: one partial-product step per clock.
// Define MUL_SIGNED_EN for two's-complement operands and product (sign-magnitude internally).
module mul_seq #(
    parameter int WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [WIDTH-1:0]     A_i,
    input  logic [WIDTH-1:0]     B_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [2*WIDTH-1:0]   P_o
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   p_q, p_d;

    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   acc_step;
    logic [2*WIDTH-1:0]   p_final;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic                 last_step;

`ifdef MUL_SIGNED_EN
    logic                 sign_q, sign_d;

    // -2^(WIDTH-1) negates to itself, which read as unsigned is the right magnitude.
    assign a_mag   = A_i[WIDTH-1] ? (~A_i + 1'b1) : A_i;
    assign b_mag   = B_i[WIDTH-1] ? (~B_i + 1'b1) : B_i;
    assign p_final = sign_q ? (~acc_step + 1'b1) : acc_step;
`else
    assign a_mag   = A_i;
    assign b_mag   = B_i;
    assign p_final = acc_step;
`endif

    // Carry out of the (WIDTH+1)-bit add becomes the top bit after the right shift.
    always_comb begin
        sum       = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        acc_step  = {sum, acc_q[WIDTH-1:1]};
        last_step = (cnt_q == CW'(WIDTH - 1));
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            mcand_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
`ifdef MUL_SIGNED_EN
            sign_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
`ifdef MUL_SIGNED_EN
            sign_q  <= sign_d;
`endif
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
`ifdef MUL_SIGNED_EN
        sign_d  = sign_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    mcand_d = a_mag;
                    acc_d   = {{WIDTH{1'b0}}, b_mag};
                    cnt_d   = '0;
`ifdef MUL_SIGNED_EN
                    sign_d  = A_i[WIDTH-1] ^ B_i[WIDTH-1];
`endif
                    state_d = BUSY;
                end
            end
            BUSY: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 1'b1;
                if (last_step) begin
                    p_d     = p_final;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode flops only
    always_comb begin
        in_ready_o  = (state_q == IDLE);
        out_valid_o = (state_q == DONE);
        P_o         = p_q;
    end

endmodule
